// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter and sequencer for a shared
// combinational ALU.
//
// The block accepts one operation at a time and registers its operands.
// It drives the operands to the ALU for one cycle, then captures the result.
// The result is returned only to the requester that issued the operation.
//
// Build option ALU_ARB_FLAGS_EN:
//   defined   - status flags are captured; C and O are kept only for ADD and SUB.
//   undefined - no flag registers are built and rsp_flags reads 4'b0000.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | wait for a request; the grant is combinational from the valids
// EXEC  | the latched operation is on the ALU; result captured at cycle end
// RESP  | result held for the granted requester until it is consumed
module alu_arbiter #(
  parameter int              WIDTH  = 16,
  parameter int              OPW    = 4,
  parameter logic [OPW-1:0]  NOP_OP = {OPW{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_o,
  input  logic             alu_c,

  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q;   // port granted most recently; reset to 1 so port 0 wins the first tie
  logic             gnt_q;    // port that owns the in-flight operation
  logic [OPW-1:0]   op_q,  op_d;
  logic [WIDTH-1:0] a_q,   a_d;
  logic [WIDTH-1:0] b_q,   b_d;
  logic [WIDTH-1:0] result_q;

  logic             grant0, grant1;
  logic             accept;
  logic             rsp_hs;

  // Round-robin grant: a lone requester always wins.
  // On a tie, the port that was not granted last time wins.
  assign grant0 = req0_valid & (~req1_valid |  last_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_q);

  // Payload of the winning port, latched on accept.
  assign op_d = grant1 ? req1_op : req0_op;
  assign a_d  = grant1 ? req1_a  : req0_a;
  assign b_d  = grant1 ? req1_b  : req0_b;

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    rsp_hs     = 1'b0;
    case (state_q)
      S_IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        accept     = grant0 | grant1;
        if (accept) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp0_valid = ~gnt_q;
        rsp1_valid =  gnt_q;
        rsp_hs     = gnt_q ? rsp1_ready : rsp0_ready;
        if (rsp_hs) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, grant bookkeeping, operand latches and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      op_q     <= NOP_OP;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= op_d;
        a_q    <= a_d;
        b_q    <= b_d;
        gnt_q  <= grant1;
        last_q <= grant1;
      end
      if (state_q == S_EXEC) begin
        result_q <= alu_result;
      end
    end
  end

`ifdef ALU_ARB_FLAGS_EN
  localparam logic [OPW-1:0] OP_ADD = '0;
  localparam logic [OPW-1:0] OP_SUB = {{(OPW-1){1'b0}}, 1'b1};

  logic [3:0] flags_q;
  logic       arith_op;

  // Carry and overflow only have meaning for add and subtract.
  assign arith_op = (op_q == OP_ADD) || (op_q == OP_SUB);

  // Flag capture alongside the result at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (state_q == S_EXEC) begin
      flags_q <= {alu_z, alu_n, alu_o & arith_op, alu_c & arith_op};
    end
  end

  assign rsp_flags = flags_q;
`else
  logic unused_alu_flags;

  assign unused_alu_flags = ^{alu_z, alu_n, alu_o, alu_c};
  assign rsp_flags        = 4'b0000;
`endif

  // The operands stay at their last latched values.
  // The opcode shows NOP except during EXEC.
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = (state_q == S_EXEC) ? op_q : NOP_OP;
  assign rsp_result = result_q;
  assign busy       = (state_q != S_IDLE);

endmodule
